// File: rtl/mor1kx_ticktimer_spr_arbiter.sv
// ---------------------------------------------------------------------------
// mor1kx_ticktimer_spr_arbiter
//
// Purpose:
//   Shares the tick timer SPR port (TTMR/TTCR) between the CPU SPR path and
//   the debug unit. Only one transaction is in flight at a time. It is
//   forwarded to the timer from registered copies of the winner's request.
//   Read data and a one-cycle ack go back to the winner only. A watchdog
//   aborts any access that the timer never acks.
//
// Configuration macro:
//   OR1K_TTARB_ROUND_ROBIN_EN
//     defined   : on a tie, grant the requester that did not win last time.
//     undefined : fixed priority, debug wins ties. last_grant is still kept.
//
// Parameters:
//   TIMEOUT_W   watchdog width. The access aborts after 2**TIMEOUT_W-1
//               BUSY cycles without an ack.
//
// Ports:
//   clk, rst                        clock and synchronous active-high reset
//   cpu_spr_access_i/we/addr/dat    CPU request, held until cpu_spr_ack_o
//   cpu_spr_ack_o/dat_o             one-cycle ack and read data to the CPU
//   dbg_spr_*                       same set for the debug unit
//   tt_spr_access_o/we/addr/dat     request towards the tick timer
//   tt_spr_ack_i/dat_i              timer ack and read data (may be same-cycle)
//   busy_o                          high in BUSY and RESP
//   timeout_o                       pulses with the ack of an aborted access
//
// Handshake:
//   A requester raises access_i and holds it, together with we/addr/dat,
//   until it sees its ack_o high. It may drop access_i in that same cycle,
//   because ack_o is registered. If access_i is still high in the IDLE cycle
//   after RESP, it counts as a new request. Downstream, tt_spr_access_o stays
//   high through BUSY with stable we/addr/dat until tt_spr_ack_i is sampled
//   high or the watchdog expires.
// ---------------------------------------------------------------------------
module mor1kx_ticktimer_spr_arbiter #(
  parameter int TIMEOUT_W = 4
) (
  input  logic        clk,
  input  logic        rst,

  input  logic        cpu_spr_access_i,
  input  logic        cpu_spr_we_i,
  input  logic [15:0] cpu_spr_addr_i,
  input  logic [31:0] cpu_spr_dat_i,
  output logic        cpu_spr_ack_o,
  output logic [31:0] cpu_spr_dat_o,

  input  logic        dbg_spr_access_i,
  input  logic        dbg_spr_we_i,
  input  logic [15:0] dbg_spr_addr_i,
  input  logic [31:0] dbg_spr_dat_i,
  output logic        dbg_spr_ack_o,
  output logic [31:0] dbg_spr_dat_o,

  output logic        tt_spr_access_o,
  output logic        tt_spr_we_o,
  output logic [15:0] tt_spr_addr_o,
  output logic [31:0] tt_spr_dat_o,
  input  logic        tt_spr_ack_i,
  input  logic [31:0] tt_spr_dat_i,

  output logic        busy_o,
  output logic        timeout_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_BUSY = 2'd1,
    S_RESP = 2'd2
  } state_e;

  state_e               state_q;
  logic                 win_dbg_q;   // winner of the transaction in flight
  logic                 last_dbg_q;  // last_grant: 0 = CPU, 1 = debug
  logic                 we_q;
  logic [15:0]          addr_q;
  logic [31:0]          wdat_q;
  logic [31:0]          rdat_q;
  logic                 tmo_q;
  logic [TIMEOUT_W-1:0] wd_q;
  logic [TIMEOUT_W-1:0] wd_d;
  logic                 grant_dbg_d;
  logic                 any_req;
  logic                 wd_expire;

  assign any_req = cpu_spr_access_i | dbg_spr_access_i;

`ifdef OR1K_TTARB_ROUND_ROBIN_EN
  // On a tie, hand the grant to whoever did not win last time.
  always_comb begin
    grant_dbg_d = dbg_spr_access_i;
    if (cpu_spr_access_i && dbg_spr_access_i) begin
      grant_dbg_d = ~last_dbg_q;
    end
  end
`else
  // Debug always wins ties. last_grant is tracked but does not steer.
  logic unused_last_grant;
  assign unused_last_grant = last_dbg_q;
  always_comb begin
    grant_dbg_d = dbg_spr_access_i;
  end
`endif

  // The watchdog expires when the count would reach all-ones. That happens
  // on the (2**TIMEOUT_W-1)-th BUSY cycle, counted from a cleared counter.
  assign wd_d      = wd_q + {{(TIMEOUT_W-1){1'b0}}, 1'b1};
  assign wd_expire = (wd_d == {TIMEOUT_W{1'b1}});

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      win_dbg_q  <= 1'b0;
      last_dbg_q <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdat_q     <= '0;
      rdat_q     <= '0;
      tmo_q      <= 1'b0;
      wd_q       <= '0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (any_req) begin
            win_dbg_q <= grant_dbg_d;
            we_q      <= grant_dbg_d ? dbg_spr_we_i   : cpu_spr_we_i;
            addr_q    <= grant_dbg_d ? dbg_spr_addr_i : cpu_spr_addr_i;
            wdat_q    <= grant_dbg_d ? dbg_spr_dat_i  : cpu_spr_dat_i;
            tmo_q     <= 1'b0;
            wd_q      <= '0;
            state_q   <= S_BUSY;
          end
        end
        S_BUSY: begin
          // An ack in the expiry cycle still counts as a normal completion.
          if (tt_spr_ack_i) begin
            rdat_q  <= tt_spr_dat_i;
            tmo_q   <= 1'b0;
            state_q <= S_RESP;
          end else if (wd_expire) begin
            rdat_q  <= '0;
            tmo_q   <= 1'b1;
            wd_q    <= wd_d;
            state_q <= S_RESP;
          end else begin
            wd_q    <= wd_d;
          end
        end
        S_RESP: begin
          last_dbg_q <= win_dbg_q;
          state_q    <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  // All outputs decode directly from registers, so they carry no
  // combinational path from the inputs.
  logic in_busy;
  logic in_resp;
  assign in_busy = (state_q == S_BUSY);
  assign in_resp = (state_q == S_RESP);

  assign tt_spr_access_o = in_busy;
  assign tt_spr_we_o     = in_busy & we_q;
  assign tt_spr_addr_o   = in_busy ? addr_q : 16'h0000;
  assign tt_spr_dat_o    = in_busy ? wdat_q : 32'h0000_0000;

  assign cpu_spr_ack_o   = in_resp & ~win_dbg_q;
  assign dbg_spr_ack_o   = in_resp &  win_dbg_q;
  assign cpu_spr_dat_o   = cpu_spr_ack_o ? rdat_q : 32'h0000_0000;
  assign dbg_spr_dat_o   = dbg_spr_ack_o ? rdat_q : 32'h0000_0000;

  assign busy_o          = (state_q != S_IDLE);
  assign timeout_o       = in_resp & tmo_q;

endmodule

// File: tb/tb_mor1kx_ticktimer_spr_arbiter.sv
module tb_mor1kx_ticktimer_spr_arbiter;

  // -------------------------------------------------------------------------
  // Clock and reset
  // -------------------------------------------------------------------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  logic        cpu_access = 1'b0, cpu_we = 1'b0;
  logic [15:0] cpu_addr = '0;
  logic [31:0] cpu_wdat = '0;
  logic        cpu_ack;
  logic [31:0] cpu_dat;
  logic        dbg_access = 1'b0, dbg_we = 1'b0;
  logic [15:0] dbg_addr = '0;
  logic [31:0] dbg_wdat = '0;
  logic        dbg_ack;
  logic [31:0] dbg_dat;
  logic        tt_access, tt_we;
  logic [15:0] tt_addr;
  logic [31:0] tt_wdat;
  logic        tt_ack;
  logic [31:0] tt_rdat = '0;
  logic        busy, timeout;

  // Timer model: acks in BUSY cycle number ack_delay+1 of each access.
  // ack_delay = 255 means the timer never acks.
  logic [7:0] ack_delay = 8'd0;
  logic [7:0] bc = 8'd0;
  always @(posedge clk) bc <= tt_access ? bc + 8'd1 : 8'd0;
  assign tt_ack = tt_access && (bc == ack_delay);

  mor1kx_ticktimer_spr_arbiter #(.TIMEOUT_W(4)) dut (
    .clk(clk), .rst(rst),
    .cpu_spr_access_i(cpu_access), .cpu_spr_we_i(cpu_we),
    .cpu_spr_addr_i(cpu_addr), .cpu_spr_dat_i(cpu_wdat),
    .cpu_spr_ack_o(cpu_ack), .cpu_spr_dat_o(cpu_dat),
    .dbg_spr_access_i(dbg_access), .dbg_spr_we_i(dbg_we),
    .dbg_spr_addr_i(dbg_addr), .dbg_spr_dat_i(dbg_wdat),
    .dbg_spr_ack_o(dbg_ack), .dbg_spr_dat_o(dbg_dat),
    .tt_spr_access_o(tt_access), .tt_spr_we_o(tt_we),
    .tt_spr_addr_o(tt_addr), .tt_spr_dat_o(tt_wdat),
    .tt_spr_ack_i(tt_ack), .tt_spr_dat_i(tt_rdat),
    .busy_o(busy), .timeout_o(timeout)
  );

  // -------------------------------------------------------------------------
  // Checking
  // -------------------------------------------------------------------------
  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Waits up to 40 cycles for an ack on either port and reports who got it.
  task automatic wait_ack(output logic got_dbg, output logic [31:0] dat,
                          output logic to, output int cyc);
    got_dbg = 1'b0; dat = '0; to = 1'b0; cyc = 0;
    for (int i = 1; i <= 40; i++) begin
      tick();
      if (cpu_ack || dbg_ack) begin
        got_dbg = dbg_ack;
        dat     = dbg_ack ? dbg_dat : cpu_dat;
        to      = timeout;
        cyc     = i;
        check("single_ack", {31'b0, cpu_ack & dbg_ack}, 32'd0);
        check("loser_dat", dbg_ack ? cpu_dat : dbg_dat, 32'd0);
        return;
      end
    end
    check("ack_budget", {31'b0, cpu_ack | dbg_ack}, 32'd1);
  endtask

  logic        g_dbg, g_to;
  logic [31:0] g_dat;
  int          g_cyc;
  logic [3:0]  exp_order;
  int          ack_cnt, ack_cyc;

  initial begin
    // Reset state
    repeat (3) tick();
    check("rst_tt_access", {31'b0, tt_access}, 32'd0);
    check("rst_busy", {31'b0, busy}, 32'd0);
    check("rst_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    check("rst_dbg_ack", {31'b0, dbg_ack}, 32'd0);
    check("rst_cpu_dat", cpu_dat, 32'd0);
    check("rst_tt_addr", {16'b0, tt_addr}, 32'd0);
    rst = 1'b0;
    tick();

    // CPU read TTCR, timer acks same cycle: ack at N+2
    ack_delay = 8'd0; tt_rdat = 32'h0000_1234;
    cpu_access = 1'b1; cpu_we = 1'b0; cpu_addr = 16'h5001;
    check("rd_idle_busy", {31'b0, busy}, 32'd0);
    tick();
    check("rd_n1_access", {31'b0, tt_access}, 32'd1);
    check("rd_n1_addr", {16'b0, tt_addr}, 32'h5001);
    check("rd_n1_we", {31'b0, tt_we}, 32'd0);
    check("rd_n1_busy", {31'b0, busy}, 32'd1);
    tick();
    check("rd_n2_cpu_ack", {31'b0, cpu_ack}, 32'd1);
    check("rd_n2_cpu_dat", cpu_dat, 32'h0000_1234);
    check("rd_n2_dbg_ack", {31'b0, dbg_ack}, 32'd0);
    check("rd_n2_timeout", {31'b0, timeout}, 32'd0);
    check("rd_n2_busy", {31'b0, busy}, 32'd1);
    cpu_access = 1'b0;
    tick();
    check("rd_n3_cpu_ack", {31'b0, cpu_ack}, 32'd0);
    check("rd_n3_busy", {31'b0, busy}, 32'd0);
    tick();

    // Tie: both requesters hold access for 4 transactions
`ifdef OR1K_TTARB_ROUND_ROBIN_EN
    exp_order = 4'b0101;  // bit i = 1 means debug wins transaction i
`else
    exp_order = 4'b1111;
`endif
    tt_rdat = 32'h0000_0055;
    cpu_access = 1'b1; cpu_addr = 16'h5001;
    dbg_access = 1'b1; dbg_addr = 16'h5000; dbg_we = 1'b0;
    for (int i = 0; i < 4; i++) begin
      wait_ack(g_dbg, g_dat, g_to, g_cyc);
      check($sformatf("tie_grant%0d", i), {31'b0, g_dbg}, {31'b0, exp_order[i]});
      check($sformatf("tie_dat%0d", i), g_dat, 32'h0000_0055);
    end
    cpu_access = 1'b0; dbg_access = 1'b0;
    repeat (2) tick();

    // Timer never acks: abort after 15 BUSY cycles
    ack_delay = 8'd255; tt_rdat = 32'hDEAD_BEEF;
    cpu_access = 1'b1; cpu_addr = 16'h5001;
    wait_ack(g_dbg, g_dat, g_to, g_cyc);
    cpu_access = 1'b0;
    check("to_cycles", g_cyc, 32'd16);
    check("to_who", {31'b0, g_dbg}, 32'd0);
    check("to_dat", g_dat, 32'd0);
    check("to_flag", {31'b0, g_to}, 32'd1);
    tick();
    check("to_flag_clear", {31'b0, timeout}, 32'd0);
    tick();

    // Timer acks on the watchdog expiry cycle: normal completion
    ack_delay = 8'd14;
    cpu_access = 1'b1;
    wait_ack(g_dbg, g_dat, g_to, g_cyc);
    cpu_access = 1'b0;
    check("edge_cycles", g_cyc, 32'd16);
    check("edge_dat", g_dat, 32'hDEAD_BEEF);
    check("edge_flag", {31'b0, g_to}, 32'd0);
    repeat (2) tick();

    // Debug write TTMR, timer acks in the 4th BUSY cycle
    ack_delay = 8'd3; tt_rdat = 32'h0000_00AA;
    dbg_access = 1'b1; dbg_we = 1'b1; dbg_addr = 16'h5000; dbg_wdat = 32'h6000_0010;
    ack_cnt = 0; ack_cyc = 0;
    for (int i = 1; i <= 10; i++) begin
      tick();
      if (tt_access) begin
        check("wr_we", {31'b0, tt_we}, 32'd1);
        check("wr_addr", {16'b0, tt_addr}, 32'h5000);
        check("wr_dat", tt_wdat, 32'h6000_0010);
      end
      check("wr_cpu_ack", {31'b0, cpu_ack}, 32'd0);
      if (dbg_ack) begin
        ack_cnt++;
        ack_cyc = i;
        check("wr_ack_dat", dbg_dat, 32'h0000_00AA);
        dbg_access = 1'b0; dbg_we = 1'b0;
      end
    end
    check("wr_ack_count", ack_cnt, 32'd1);
    check("wr_ack_cycle", ack_cyc, 32'd5);

    // Reset asserted in BUSY: back to IDLE, no ack afterwards
    ack_delay = 8'd255;
    cpu_access = 1'b1; cpu_addr = 16'h5001;
    repeat (3) tick();
    check("rb_busy_before", {31'b0, busy}, 32'd1);
    rst = 1'b1; cpu_access = 1'b0;
    tick();
    check("rb_tt_access", {31'b0, tt_access}, 32'd0);
    check("rb_busy", {31'b0, busy}, 32'd0);
    rst = 1'b0;
    ack_cnt = 0;
    for (int i = 0; i < 20; i++) begin
      if (cpu_ack || dbg_ack) ack_cnt++;
      tick();
    end
    check("rb_no_ack", ack_cnt, 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
